// File: rtl/wb_quadrature_gen.sv
// Wishbone-programmed rotary-encoder emulator: emits Gray-coded A/B detent
// steps and an active-low switch pulse on flop-driven pins.
module wb_quadrature_gen #(
   parameter int DATA_WIDTH      = 8,
   parameter int REG_ADDR_STEPS  = 0,
   parameter int REG_ADDR_PERIOD = 1,
   parameter int REG_ADDR_CTRL   = 2,
   parameter int PRESCALE        = 1000,
   parameter int SW_HOLD_CYCLES  = 50000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [DATA_WIDTH-1:0] adr_wr_i,
   input  logic [DATA_WIDTH-1:0] adr_rd_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic                  ack_o,
   output logic                  enc_clk_o,
   output logic                  enc_dt_o,
   output logic                  enc_sw_o
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (SW_HOLD_CYCLES > 1) ? $clog2(SW_HOLD_CYCLES + 1) : 1;
   localparam logic [PW-1:0]         PRESC_LAST  = PW'(PRESCALE - 1);
   localparam logic [SW-1:0]         SW_LOAD     = SW'(SW_HOLD_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] ADDR_STEPS  = DATA_WIDTH'(REG_ADDR_STEPS);
   localparam logic [DATA_WIDTH-1:0] ADDR_PERIOD = DATA_WIDTH'(REG_ADDR_PERIOD);
   localparam logic [DATA_WIDTH-1:0] ADDR_CTRL   = DATA_WIDTH'(REG_ADDR_CTRL);
   localparam logic [DATA_WIDTH-1:0] ONE_D       = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] ZERO_D      = DATA_WIDTH'(0);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                  state_r;
   logic                    wr_pend_r;
   logic [DATA_WIDTH-1:0]   wr_adr_r;
   logic [DATA_WIDTH-1:0]   wr_dat_r;
   logic [DATA_WIDTH-1:0]   remaining_r;
   logic [DATA_WIDTH-1:0]   period_r;
   logic [DATA_WIDTH-1:0]   per_q_r;
   logic [DATA_WIDTH-1:0]   tick_cnt_r;
   logic [PW-1:0]           presc_cnt_r;
   logic [1:0]              phase_idx_r;
   logic                    dir_ccw_r;
   logic                    ovr_r;
   logic [SW-1:0]           sw_cnt_r;
   logic                    enc_clk_r;
   logic                    enc_dt_r;
   logic                    enc_sw_r;

   logic                    wr_steps_s;
   logic                    wr_period_s;
   logic                    wr_ctrl_s;
   logic                    abort_s;
   logic                    press_s;
   logic                    clr_ovr_s;
   logic [DATA_WIDTH-1:0]   period_eff_s;
   logic                    quarter_end_s;
   logic [DATA_WIDTH-1:0]   remaining_next_s;
   logic [DATA_WIDTH-1:0]   rd_data_s;

   // {A,B} code for a quarter phase; both directions end a detent on 11
   function automatic logic [1:0] quad_code_f(input logic ccw, input logic [1:0] idx);
      logic [1:0] code;
      case (idx)
         2'd0:    code = ccw ? 2'b10 : 2'b01;
         2'd1:    code = 2'b00;
         2'd2:    code = ccw ? 2'b01 : 2'b10;
         2'd3:    code = 2'b11;
         default: code = 2'b11;
      endcase
      return code;
   endfunction

   // Decode of the write captured on the previous edge
   always_comb begin
      wr_steps_s  = wr_pend_r && (wr_adr_r == ADDR_STEPS);
      wr_period_s = wr_pend_r && (wr_adr_r == ADDR_PERIOD);
      wr_ctrl_s   = wr_pend_r && (wr_adr_r == ADDR_CTRL);
      abort_s     = wr_ctrl_s && wr_dat_r[1];
      press_s     = wr_ctrl_s && wr_dat_r[0] && !wr_dat_r[1];
      clr_ovr_s   = wr_ctrl_s && wr_dat_r[2];
      if (period_r == ZERO_D) begin
         period_eff_s = ONE_D;
      end else begin
         period_eff_s = period_r;
      end
      quarter_end_s = (presc_cnt_r == PRESC_LAST) && (tick_cnt_r == per_q_r - ONE_D);
      if (dir_ccw_r) begin
         remaining_next_s = remaining_r + ONE_D;
      end else begin
         remaining_next_s = remaining_r - ONE_D;
      end
   end

   // Register the Wishbone write so it takes effect one edge later
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_pend_r <= 1'b0;
         wr_adr_r  <= ZERO_D;
         wr_dat_r  <= ZERO_D;
      end else begin
         wr_pend_r <= stb_i && we_i;
         if (stb_i && we_i) begin
            wr_adr_r <= adr_wr_i;
            wr_dat_r <= dat_i;
         end
      end
   end

   // Period register and sticky overrun flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         period_r <= ONE_D;
         ovr_r    <= 1'b0;
      end else begin
         if (wr_period_s) begin
            period_r <= wr_dat_r;
         end
         if (wr_steps_s && (state_r == ST_RUN)) begin
            ovr_r <= 1'b1;
         end else if (clr_ovr_s) begin
            ovr_r <= 1'b0;
         end
      end
   end

   // Step sequencer: prescaler, quarter-phase timing and A/B output flops
   always_ff @(posedge clk) begin
      if (!reset_n || abort_s) begin
         state_r     <= ST_IDLE;
         remaining_r <= ZERO_D;
         per_q_r     <= ONE_D;
         tick_cnt_r  <= ZERO_D;
         presc_cnt_r <= '0;
         phase_idx_r <= 2'd0;
         dir_ccw_r   <= 1'b0;
         enc_clk_r   <= 1'b1;
         enc_dt_r    <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               enc_clk_r <= 1'b1;
               enc_dt_r  <= 1'b1;
               if (wr_steps_s && (wr_dat_r != ZERO_D)) begin
                  state_r                <= ST_RUN;
                  remaining_r            <= wr_dat_r;
                  dir_ccw_r              <= wr_dat_r[DATA_WIDTH-1];
                  phase_idx_r            <= 2'd0;
                  presc_cnt_r            <= '0;
                  tick_cnt_r             <= ZERO_D;
                  per_q_r                <= period_eff_s;
                  {enc_clk_r, enc_dt_r}  <= quad_code_f(wr_dat_r[DATA_WIDTH-1], 2'd0);
               end
            end
            ST_RUN: begin
               if (presc_cnt_r == PRESC_LAST) begin
                  presc_cnt_r <= '0;
                  if (quarter_end_s) begin
                     tick_cnt_r <= ZERO_D;
                     per_q_r    <= period_eff_s;
                     if (phase_idx_r == 2'd3) begin
                        remaining_r <= remaining_next_s;
                        phase_idx_r <= 2'd0;
                        if (remaining_next_s == ZERO_D) begin
                           state_r   <= ST_IDLE;
                           enc_clk_r <= 1'b1;
                           enc_dt_r  <= 1'b1;
                        end else begin
                           {enc_clk_r, enc_dt_r} <= quad_code_f(dir_ccw_r, 2'd0);
                        end
                     end else begin
                        phase_idx_r           <= phase_idx_r + 2'd1;
                        {enc_clk_r, enc_dt_r} <= quad_code_f(dir_ccw_r, phase_idx_r + 2'd1);
                     end
                  end else begin
                     tick_cnt_r <= tick_cnt_r + ONE_D;
                  end
               end else begin
                  presc_cnt_r <= presc_cnt_r + PW'(1);
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               enc_clk_r <= 1'b1;
               enc_dt_r  <= 1'b1;
            end
         endcase
      end
   end

   // Switch pulse: a press (re)loads the full hold, abort releases at once
   always_ff @(posedge clk) begin
      if (!reset_n || abort_s) begin
         enc_sw_r <= 1'b1;
         sw_cnt_r <= '0;
      end else if (press_s) begin
         enc_sw_r <= 1'b0;
         sw_cnt_r <= SW_LOAD;
      end else if (sw_cnt_r != '0) begin
         sw_cnt_r <= sw_cnt_r - SW'(1);
      end else begin
         enc_sw_r <= 1'b1;
      end
   end

   // Combinational read mux
   always_comb begin
      if (adr_rd_i == ADDR_STEPS) begin
         rd_data_s = remaining_r;
      end else if (adr_rd_i == ADDR_PERIOD) begin
         rd_data_s = period_r;
      end else if (adr_rd_i == ADDR_CTRL) begin
         rd_data_s = {{(DATA_WIDTH-4){1'b0}}, ovr_r, ~enc_sw_r, (state_r == ST_RUN), phase_idx_r[0]};
      end else begin
         rd_data_s = ZERO_D;
      end
   end

   assign dat_o     = rd_data_s;
   assign ack_o     = stb_i;
   assign enc_clk_o = enc_clk_r;
   assign enc_dt_o  = enc_dt_r;
   assign enc_sw_o  = enc_sw_r;

endmodule

// File: doc/wb_quadrature_gen.md
Name: wb_quadrature_gen

Overview:
- Wishbone-controlled quadrature signal generator that emulates an incremental rotary encoder: the transmitting end of the encoder_clk / encoder_dt / encoder_sw interface.
- Software programs a signed detent count, a phase period and switch presses; the block emits the matching Gray-code A/B waveform and an active-low switch pulse.
- Drives the encoder pins of the rotary-encoder decoder for in-system self-test, and also serves as a bench stimulus source.

Parameters:
- DATA_WIDTH, 8, Wishbone data/address width.
- REG_ADDR_STEPS, 0, address of signed step-count register.
- REG_ADDR_PERIOD, 1, address of quarter-phase period register.
- REG_ADDR_CTRL, 2, address of control (write) / status (read) register.
- PRESCALE, 1000, clocks per period tick; must be ≥1.
- SW_HOLD_CYCLES, 50000, clocks the switch output is held low per press.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- stb_i  input  1  Wishbone strobe
- we_i  input  1  write enable
- adr_wr_i  input  DATA_WIDTH  write address
- adr_rd_i  input  DATA_WIDTH  read address
- dat_i  input  DATA_WIDTH  write data
- dat_o  output  DATA_WIDTH  read data
- ack_o  output  1  acknowledge
- enc_clk_o  output  1  quadrature A, idle high
- enc_dt_o  output  1  quadrature B, idle high
- enc_sw_o  output  1  switch, active low, idle high

Behaviour:
Interface and reset:
- One clock. reset_n is synchronous and active-low.
- On reset:
  - enc_clk_o, enc_dt_o and enc_sw_o = 1.
  - Remaining steps = 0, period register = 1, FSM = IDLE.
  - Sticky overrun flag = 0, prescaler and counters = 0.
  - dat_o reflects the reset registers.
- Reset asserted mid-operation aborts immediately at that edge; no partial step completes.

Wishbone timing:
- ack_o = stb_i (combinational).
- Writes: stb_i & we_i, adr_wr_i and dat_i are registered. The register update happens on the following edge (1-cycle write latency).
- Reads: combinational on adr_rd_i.
  - STEPS returns signed remaining steps.
  - PERIOD returns the period register.
  - CTRL returns {0…, ovr[3], sw_active[2], busy[1], phase_idx_bit0[0]}.
  - Any other address returns 0.

Registers:
- STEPS write, two's complement:
  - Accepted only in IDLE. Positive = clockwise (CW), negative = counter-clockwise (CCW), 0 = no-op.
  - A write while busy is ignored and sets ovr.
- PERIOD write: quarter-phase length = max(PERIOD,1) × PRESCALE clocks. It is sampled at the start of each quarter phase.
- CTRL write bits:
  - bit0 = switch press.
  - bit1 = abort.
  - bit2 = clear ovr.
  - Multiple bits may be set together; abort beats press.

FSM (IDLE, RUN):
- IDLE:
  - Outputs A,B = 1,1.
  - Enter RUN on the edge after the registered STEPS write if the value ≠ 0.
  - Latch direction = sign, phase_idx = 0, and restart the prescaler.
- RUN: each step is 4 quarter phases; A/B hold each code for one quarter phase.
  - CW sequence: 01, 00, 10, 11.
  - CCW sequence: 10, 00, 01, 11.
  - The first code appears on the clock edge entering RUN.
- At expiry of the 4th quarter (outputs already 11):
  - Remaining moves one toward zero.
  - If the result is 0, go to IDLE; otherwise start the next step with phase_idx = 0 in the same edge. No extra idle cycle is inserted.
- −128 is legal: it yields 128 CCW steps with no overflow.
- busy = (state == RUN).

Abort:
- On the edge the registered abort write takes effect: state = IDLE, remaining = 0, A/B = 11, enc_sw_o = 1, hold counter cleared.
- Abort takes precedence over a same-cycle step completion.

Switch:
- A press forces enc_sw_o = 0 for exactly SW_HOLD_CYCLES clocks, then it returns to 1.
- It is independent of rotation.
- A press while already active restarts the full hold.
- sw_active = ~enc_sw_o.

Glitch rule:
- All enc_* outputs are direct flop outputs.
- Exactly one of A/B changes per quarter-phase boundary.

Test Plan:
1. Reset, then PRESCALE=4, PERIOD=2, write STEPS=+1:
   - A/B go 01,00,10,11, each held 8 clks.
   - busy is high for 32 clks, then remaining = 0 and busy drops.
2. Write STEPS=−3 (0xFD):
   - 3 CCW cycles of 10,00,01,11 back-to-back (96 clks).
   - STEPS reads FD→FE→FF→00 at step boundaries.
3. While busy, write STEPS=5:
   - Ignored; the original sequence completes unchanged.
   - CTRL bit3 = 1; writing CTRL=0x04 clears it.
4. Mid-step (phase 2 of STEPS=+4), write CTRL=0x02:
   - Next edge A/B = 11, busy = 0, STEPS reads 0.
5. Write CTRL=0x01 with SW_HOLD_CYCLES=20:
   - enc_sw_o low exactly 20 clks.
   - A second press at clk 10 extends the low time to 30 clks total.
   - A concurrent rotation is unaffected.
6. Assert reset_n=0 for one edge during RUN with STEPS=−128:
   - All outputs = 1, busy = 0, STEPS = 0, PERIOD = 1 after that edge.
   - Writing PERIOD=0 then STEPS=1 gives PRESCALE-clock quarter phases.
